// File: rtl/panda_data_mem.sv
// panda_data_mem: data-memory responder for the Panda core data port.
//
// A req/gnt/rvalid responder. Requests are granted in IDLE or RESP, latched at
// the accepting edge, then complete after WAIT_CYCLES wait states. The word
// array is updated, or read into the response register, on the edge that
// enters RESP ("commit edge"). Each accepted request gets exactly one
// single-cycle rvalid strobe.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   data_req_i     request valid
//   data_gnt_o     request granted this cycle (combinational)
//   data_addr_i    byte address, bits [1:0] ignored
//   data_we_i      byte write enables, 4'b0000 = read
//   data_wdata_i   write data
//   data_rvalid_o  one-cycle response strobe
//   data_rdata_o   read data (zero for writes), held between responses
//   data_err_o     error flag, valid with data_rvalid_o
//
// Configuration macro: PANDA_DMEM_ERR_EN
//   defined   - addresses outside the window respond with err=1, rdata=0 and
//               leave the array untouched
//   undefined - the word index wraps modulo DEPTH_WORDS, data_err_o is 0
module panda_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            oor_q, oor_d;
  logic [3:0]      we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            gnt;
  logic            accept;
  logic            commit;
  logic [31:0]     req_off;
  logic [AW-1:0]   req_idx;
  logic            req_oor;

  // Payload of the transaction being committed on this edge.
  logic [AW-1:0]   cm_idx;
  logic [3:0]      cm_we;
  logic [31:0]     cm_wdata;
  logic            cm_oor;

  // Address decode of the incoming request.
  assign req_off = data_addr_i - BASE_ADDR;
  assign req_idx = req_off[AW+1:2];
`ifdef PANDA_DMEM_ERR_EN
  // Addresses below BASE_ADDR wrap to huge offsets and are caught here too.
  assign req_oor = (req_off[31:2] >= 30'(DEPTH_WORDS));
  logic unused_off;
  assign unused_off = ^req_off[1:0];
`else
  assign req_oor = 1'b0;
  logic unused_off;
  assign unused_off = ^{req_off[31:AW+2], req_off[1:0]};
`endif

  assign accept = data_req_i & gnt;

  // With zero wait states the accepting edge is also the commit edge, so the
  // payload comes straight from the ports rather than the latches.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      cm_idx   = req_idx;
      cm_we    = data_we_i;
      cm_wdata = data_wdata_i;
      cm_oor   = req_oor;
    end else begin
      cm_idx   = idx_q;
      cm_we    = we_q;
      cm_wdata = wdata_q;
      cm_oor   = oor_q;
    end
  end

  // RESP is only re-entered from RESP by a new accept, so every entry is a commit.
  assign commit = (state_d == StResp);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      we_q     <= 4'd0;
      wdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      oor_q    <= oor_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    oor_d    = oor_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rvalid_d = commit;
    rdata_d  = rdata_q;
    err_d    = err_q;

    if (accept) begin
      idx_d   = req_idx;
      oor_d   = req_oor;
      we_d    = data_we_i;
      wdata_d = data_wdata_i;
    end

    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      err_d   = cm_oor;
      rdata_d = (cm_we == 4'd0 && !cm_oor) ? mem_q[cm_idx] : 32'd0;
    end
  end

  // Word array: not reset; only written on a commit edge.
  always_ff @(posedge clk_i) begin
    if (commit && !cm_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (cm_we[b]) begin
          mem_q[cm_idx][8*b +: 8] <= cm_wdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    gnt           = data_req_i && rst_ni && (state_q == StIdle || state_q == StResp);
    data_gnt_o    = gnt;
    data_rvalid_o = rvalid_q;
    data_rdata_o  = rdata_q;
    data_err_o    = err_q;
  end

endmodule

// File: tb/tb_panda_data_mem.sv
module tb_panda_data_mem;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic [31:0] addr   [3];
  logic [3:0]  we_s   [3];
  logic [31:0] wd     [3];
  logic        gnt    [3];
  logic        rv     [3];
  logic [31:0] rd     [3];
  logic        er     [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=1, 2: WAIT_CYCLES=3.
  panda_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_addr_i(addr[0]), .data_we_i(we_s[0]), .data_wdata_i(wd[0]),
    .data_rvalid_o(rv[0]), .data_rdata_o(rd[0]), .data_err_o(er[0])
  );
  panda_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_addr_i(addr[1]), .data_we_i(we_s[1]), .data_wdata_i(wd[1]),
    .data_rvalid_o(rv[1]), .data_rdata_o(rd[1]), .data_err_o(er[1])
  );
  panda_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_addr_i(addr[2]), .data_we_i(we_s[2]), .data_wdata_i(wd[2]),
    .data_rvalid_o(rv[2]), .data_rdata_o(rd[2]), .data_err_o(er[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard when the DUT answers.
  task automatic mon(input int k);
    exp_t e;
    if (q_size(k) == 0) begin
      chk($sformatf("rv_idle%0d", k), 32'(rv[k]), 32'd0);
    end else begin
      e = q_front(k);
      if (rv[k] === 1'b1) begin
        q_pop(k);
        chk($sformatf("rv_cycle%0d", k), 32'(cyc), 32'(e.due));
        chk($sformatf("rdata%0d", k), rd[k], e.rdata);
        chk($sformatf("err%0d", k), 32'(er[k]), 32'(e.err));
      end else if (cyc >= e.due) begin
        q_pop(k);
        chk($sformatf("rv_missing%0d", k), 32'(rv[k]), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) mon(k);
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic issue(input int k, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wdat, input logic [31:0] exp_rd,
                       input logic exp_err, input bit push, output int waited);
    exp_t e;
    bit   done;
    int   w;
    done    = 0;
    w       = 0;
    req[k]  = 1'b1;
    addr[k] = a;
    we_s[k] = we;
    wd[k]   = wdat;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (gnt[k] === 1'b1) begin
        done = 1;
        if (push) begin
          e.rdata = exp_rd;
          e.err   = exp_err;
          e.due   = cyc + 1 + wc(k);
          q_push(k, e);
        end
      end else begin
        w++;
      end
    end
    chk($sformatf("gnt_seen%0d", k), 32'(done), 32'd1);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    waited = w;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 40 && q_size(k) != 0; i++) @(negedge clk);
    chk($sformatf("drain%0d", k), 32'(q_size(k)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; addr[k] = '0; we_s[k] = '0; wd[k] = '0;
    end

    // Reset values, and no grant while in reset even with req high.
    req[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt[1]), 32'd0);
    chk("rst_rvalid", 32'(rv[1]), 32'd0);
    chk("rst_rdata", rd[1], 32'd0);
    chk("rst_err", 32'(er[1]), 32'd0);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1;

    // WAIT_CYCLES=1: write then read word 0.
    issue(1, 32'h0, 4'hF, 32'h0000_0CD4, 32'h0, 1'b0, 1, w);
    chk("w1_first_wait", 32'(w), 32'd0);
    drain(1);
    issue(1, 32'h0, 4'h0, 32'h0, 32'h0000_0CD4, 1'b0, 1, w);
    drain(1);
    @(negedge clk);
    chk("rdata_hold", rd[1], 32'h0000_0CD4);
    @(posedge clk);
    #1;

    // Byte lanes; second write granted in the RESP cycle of the first.
    issue(1, 32'h8, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 1, w);
    issue(1, 32'h8, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, 1, w);
    chk("w1_resp_grant_wait", 32'(w), 32'd1);
    issue(1, 32'h8, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0, 1, w);
    drain(1);

    // WAIT_CYCLES=0: back-to-back write then read.
    issue(0, 32'h4, 4'hF, 32'h0000_1510, 32'h0, 1'b0, 1, w);
    chk("w0_wait_a", 32'(w), 32'd0);
    issue(0, 32'h4, 4'h0, 32'h0, 32'h0000_1510, 1'b0, 1, w);
    chk("w0_wait_b", 32'(w), 32'd0);
    drain(0);

    // WAIT_CYCLES=3: second request held through WAIT, granted in RESP.
    issue(2, 32'h10, 4'hF, 32'h0000_0077, 32'h0, 1'b0, 1, w);
    issue(2, 32'h10, 4'h0, 32'h0, 32'h0000_0077, 1'b0, 1, w);
    chk("w3_held_wait", 32'(w), 32'd3);
    drain(2);

    // Reset during WAIT of a write: dropped, no response, no array update.
    issue(1, 32'hC, 4'hF, 32'h0, 32'h0, 1'b0, 1, w);
    drain(1);
    issue(1, 32'hC, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, w);
    rst_n  = 1'b0;
    req[1] = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req[1] = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("midrst_rdata", rd[1], 32'd0);
    chk("midrst_err", 32'(er[1]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    issue(1, 32'hC, 4'h0, 32'h0, 32'h0, 1'b0, 1, w);
    drain(1);

    // Out-of-window write to word 1024.
`ifdef PANDA_DMEM_ERR_EN
    issue(1, 32'h1000, 4'hF, 32'h5, 32'h0, 1'b1, 1, w);
    issue(1, 32'h0, 4'h0, 32'h0, 32'h0000_0CD4, 1'b0, 1, w);
`else
    issue(1, 32'h1000, 4'hF, 32'h5, 32'h0, 1'b0, 1, w);
    issue(1, 32'h0, 4'h0, 32'h0, 32'h0000_0005, 1'b0, 1, w);
`endif
    drain(1);

    drain(0);
    drain(2);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
